// File: rtl/img_bank_loader.sv
// Streams a raster-order image into four interleaved RAM banks so every 2x2
// pixel neighbourhood sits in four distinct banks at the same address.
module img_bank_loader #(
  parameter int RAM_AW = 17,
  parameter int QN     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [15:0]       img_w,
  input  logic [15:0]       img_h,
  input  logic [15:0]       start_rows,
  input  logic              s_valid,
  input  logic [QN-1:0]     s_data,
  output logic              s_ready,
  output logic              ena1,
  output logic              ena2,
  output logic              ena3,
  output logic              ena4,
  output logic              wea1,
  output logic              wea2,
  output logic              wea3,
  output logic              wea4,
  output logic [RAM_AW-1:0] AA,
  output logic [QN-1:0]     DA,
  input  logic              rsta_busy,
  output logic [31:0]       row_signal,
  output logic              img_start,
  input  logic              img_finish,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_FIN, DONE} state_t;
  state_t state, state_nxt;

  logic [15:0]       w_q, h_q, thr_q, x, y;
  logic [16:0]       half_w_q;
  logic [RAM_AW-1:0] row_base;
  logic [3:0]        strobe;
  logic              fin_flag;

  // Configuration check on the raw inputs; only used when cfg_start is seen in IDLE.
  logic [16:0] in_half_w, in_half_h;
  logic [33:0] area;
  logic [34:0] cap;
  logic [15:0] in_thr;
  logic        cfg_bad;

  assign in_half_w = {2'b00, img_w[15:1]} + {16'd0, img_w[0]};
  assign in_half_h = {2'b00, img_h[15:1]} + {16'd0, img_h[0]};
  assign area      = 34'(in_half_w) * 34'(in_half_h);
  assign cap       = 35'd1 << RAM_AW;
  assign cfg_bad   = (img_w < 16'd2) || (img_h < 16'd2) || ({1'b0, area} > cap);

  always_comb begin
    in_thr = img_h;
    if (start_rows == 16'd0)      in_thr = 16'd1;
    else if (start_rows < img_h)  in_thr = start_rows;
  end

  // Stream handshake: a pixel moves on a rising edge where s_valid && s_ready;
  // s_ready is combinational so it drops in the same cycle rsta_busy rises.
  logic load_ready, xfer, last_col, last_row;
  assign load_ready = (state == LOAD) && !rsta_busy;
  assign s_ready    = load_ready;
  assign xfer       = s_valid && load_ready;
  assign last_col   = (x == w_q - 16'd1);
  assign last_row   = (y == h_q - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:     if (cfg_start && !cfg_bad) state_nxt = LOAD;
      LOAD: begin
        busy = 1'b1;
        if (xfer && last_col && last_row) state_nxt = WAIT_FIN;
      end
      WAIT_FIN: begin
        busy = 1'b1;
        if (img_finish || fin_flag) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q        <= '0;
      h_q        <= '0;
      thr_q      <= '0;
      half_w_q   <= '0;
      x          <= '0;
      y          <= '0;
      row_base   <= '0;
      fin_flag   <= 1'b0;
      strobe     <= '0;
      AA         <= '0;
      DA         <= '0;
      row_signal <= '0;
      img_start  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      strobe    <= '0;
      img_start <= 1'b0;
      cfg_err   <= 1'b0;
      if (state == IDLE && cfg_start) begin
        if (cfg_bad) begin
          cfg_err <= 1'b1;
        end else begin
          w_q        <= img_w;
          h_q        <= img_h;
          thr_q      <= in_thr;
          half_w_q   <= in_half_w;
          x          <= '0;
          y          <= '0;
          row_base   <= '0;
          row_signal <= '0;
          fin_flag   <= 1'b0;
        end
      end
      if (state == LOAD && img_finish) fin_flag <= 1'b1;
      if (state == DONE)               fin_flag <= 1'b0;
      if (xfer) begin
        AA     <= row_base + RAM_AW'(x[15:1]);
        DA     <= s_data;
        strobe <= 4'b0001 << {y[0], x[0]};
        if (last_col) begin
          x          <= '0;
          y          <= y + 16'd1;
          // Row base advances once per pair of source rows.
          if (y[0]) row_base <= row_base + RAM_AW'(half_w_q);
          row_signal <= row_signal + 32'd1;
          if (row_signal + 32'd1 == {16'd0, thr_q}) img_start <= 1'b1;
        end else begin
          x <= x + 16'd1;
        end
      end
    end
  end

  assign ena1 = strobe[0];
  assign ena2 = strobe[1];
  assign ena3 = strobe[2];
  assign ena4 = strobe[3];
  assign wea1 = strobe[0];
  assign wea2 = strobe[1];
  assign wea3 = strobe[2];
  assign wea4 = strobe[3];

endmodule

// File: doc/img_bank_loader.md
IMG_BANK_LOADER -- requirements
Module: img_bank_loader

Interface
REQ-001 SHALL have parameter RAM_AW, default 17: bank address width.
REQ-002 SHALL have parameter QN, default 8: pixel width.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port cfg_start, input, 1: one-cycle frame start pulse.
REQ-006 SHALL have ports img_w and img_h, input, 16 each: source image size.
REQ-007 SHALL have port start_rows, input, 16: number of buffered rows before the scaler is launched.
REQ-008 SHALL have ports s_valid (input, 1), s_data (input, QN) and s_ready (output, 1): raster-order pixel stream.
REQ-009 SHALL have ports ena1..ena4 and wea1..wea4, output, 1 each: per-bank write strobes.
REQ-010 SHALL have ports AA (output, RAM_AW) and DA (output, QN): write address and data, shared by all banks.
REQ-011 SHALL have port rsta_busy, input, 1: the RAM write side is in reset.
REQ-012 SHALL have port row_signal, output, 32: count of fully written source rows.
REQ-013 SHALL have port img_start, output, 1: one-cycle launch pulse to the scaler.
REQ-014 SHALL have port img_finish, input, 1: scaler done pulse.
REQ-015 SHALL have ports busy (output, 1), done (output, 1) and cfg_err (output, 1).

Function
REQ-016 SHALL implement the states IDLE, LOAD, WAIT_FIN and DONE.
REQ-017 IDLE SHALL behave as follows: on cfg_start, latch img_w, img_h and start_rows. If img_w<2, img_h<2, or ceil(w/2)*ceil(h/2) > 2^RAM_AW, pulse cfg_err for 1 cycle and stay in IDLE; otherwise go to LOAD.
REQ-018 cfg_start SHALL be ignored outside IDLE.
REQ-019 s_ready SHALL be high only in LOAD with rsta_busy low; a pixel transfers when s_valid and s_ready are both high.
REQ-020 The bank for pixel (x,y) SHALL be selected by {y[0],x[0]}: 00 selects bank 1, 01 bank 2, 10 bank 3, 11 bank 4, so every 2x2 neighbourhood lands in 4 distinct banks.
REQ-021 The address SHALL be AA = (y>>1)*ceil(w/2) + (x>>1), generated with an incremental row base and column counter, not a multiplier.
REQ-022 Write latency SHALL be fixed: a transfer in cycle n gives registered AA/DA and exactly one enaK=weaK=1 in cycle n+1; all strobes are 0 otherwise.
REQ-023 x SHALL wrap to 0 after w-1 and y then increments.
REQ-024 row_signal SHALL increment in the same cycle as the write of pixel x=w-1.
REQ-025 img_start SHALL pulse once per frame, in the cycle row_signal first reaches max(1, min(start_rows, h)).
REQ-026 After the write of pixel (w-1, h-1), the block SHALL go to WAIT_FIN.
REQ-027 An img_finish received during LOAD SHALL be latched; WAIT_FIN SHALL go to DONE on img_finish or on the latched flag.
REQ-028 DONE SHALL pulse done for 1 cycle, then return to IDLE.
REQ-029 row_signal SHALL hold its value until the next accepted cfg_start, which clears it to 0.
REQ-030 busy SHALL be 1 in LOAD and in WAIT_FIN.
REQ-031 When rsta_busy asserts mid-LOAD, s_ready SHALL drop the same cycle; counters SHALL hold, and there is no loss or duplication of pixels.
REQ-032 All counters SHALL be sized so that x, y reach 65535 without overflow.

Reset
REQ-033 When rst is low, the block SHALL asynchronously enter IDLE.
REQ-034 Reset SHALL clear all outputs to 0: s_ready, ena1..4, wea1..4, AA, DA, row_signal, img_start, busy, done and cfg_err.
REQ-035 Reset SHALL clear the internal x, y, row base and finish flag to 0.
REQ-036 Reset asserted mid-frame SHALL abandon the frame; after release, the block SHALL wait for a new cfg_start.

Verification
REQ-037 Scenario: w=4, h=4, start_rows=2, continuous stream. Required: 16 writes; pixel(3,1) goes to bank 4 at AA=1; pixel(2,2) goes to bank 1 at AA=3; img_start pulses with the write of pixel(3,1); row_signal ends at 4.
REQ-038 Scenario: w=5, h=3 (odd sizes). Required: ceil(w/2)=3; pixel(4,2) goes to bank 1 at AA=5; no address aliasing across the 15 writes.
REQ-039 Scenario: random s_valid gaps plus rsta_busy high for 10 cycles mid-row. Required: the written sequence equals the input sequence, with exactly one strobe per transfer.
REQ-040 Scenario: img_finish pulsed during LOAD, before the last pixel. Required: WAIT_FIN lasts 1 cycle, then done pulses.
REQ-041 Scenario: cfg_start with w=1, then w=1024, h=1024 at RAM_AW=17 (requires 2^18 entries). Required: cfg_err pulses both times and busy stays 0.
REQ-042 Scenario: rst low after 7 pixels of a 4x4 frame. Required: all outputs are 0 immediately; the next frame starts at AA=0, bank 1.
